// File: rtl/alu_arbitro.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Grant in IDLE, one settling cycle in EXEC, one-cycle ack in RESP.
module alu_arbitro #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [OPW-1:0]   op0,
    output logic             ack0,
    output logic [WIDTH-1:0] res0,
    output logic             zero0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [OPW-1:0]   op1,
    output logic             ack1,
    output logic [WIDTH-1:0] res1,
    output logic             zero1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero,
    output logic             ocupado
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t r_state, w_next;
    logic   r_gnt;
    logic   r_ult;
    logic   w_grant;
    logic   w_win;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_win   = (req0 && req1) ? ~r_ult : req1;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_grant = 1'b1;
                    w_next  = EXEC;
                end
            end
            EXEC:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
            r_ult   <= 1'b1;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            res0    <= '0;
            res1    <= '0;
            zero0   <= 1'b0;
            zero1   <= 1'b0;
            ocupado <= 1'b0;
        end else begin
            r_state <= w_next;
            ocupado <= (w_next != IDLE);
            if (w_grant) begin
                r_gnt  <= w_win;
                alu_a  <= w_win ? a1  : a0;
                alu_b  <= w_win ? b1  : b0;
                alu_op <= w_win ? op1 : op0;
            end
            if (r_state == EXEC) begin
                r_ult <= r_gnt;
                if (r_gnt) begin
                    res1  <= alu_res;
                    zero1 <= alu_zero;
                    ack1  <= 1'b1;
                end else begin
                    res0  <= alu_res;
                    zero0 <= alu_zero;
                    ack0  <= 1'b1;
                end
            end
            if (r_state == RESP) begin
                ack0 <= 1'b0;
                ack1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbitro.sv
// Bench for alu_arbitro: table of single transactions, scoreboard queues per requester,
// plus hand sequences for operand change, tie alternation and mid-operation reset.
module tb_alu_arbitro;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] a0, b0, a1, b1;
    logic [3:0] op0, op1;
    logic       ack0, ack1, zero0, zero1, ocupado;
    logic [7:0] res0, res1, alu_a, alu_b, alu_res;
    logic [3:0] alu_op;
    logic       alu_zero;

    always #5 clk = ~clk;

    alu_arbitro #(.WIDTH(8), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0), .ack0(ack0), .res0(res0), .zero0(zero0),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1), .ack1(ack1), .res1(res1), .zero1(zero1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_zero(alu_zero), .ocupado(ocupado)
    );

    // Behavioural ALU fixture: 0 = add, 1 = sub.
    always_comb begin
        alu_res = 8'h00;
        case (alu_op)
            4'd0:    alu_res = alu_a + alu_b;
            4'd1:    alu_res = alu_a - alu_b;
            default: alu_res = 8'h00;
        endcase
        alu_zero = (alu_res == 8'h00);
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard entries are {zero, res}.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int         ack_log[$];
    logic       prev0 = 1'b0, prev1 = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ack0 || ack1) chk("ack_exclusive", int'(ack0 & ack1), 0);
            if (ack0) begin
                logic [8:0] e;
                chk("ack0_single_cycle", int'(prev0), 0);
                chk("ack0_expected", int'(q0.size() > 0), 1);
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    chk("res0", int'(res0), int'(e[7:0]));
                    chk("zero0", int'(zero0), int'(e[8]));
                end
                ack_log.push_back(0);
            end
            if (ack1) begin
                logic [8:0] e;
                chk("ack1_single_cycle", int'(prev1), 0);
                chk("ack1_expected", int'(q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    chk("res1", int'(res1), int'(e[7:0]));
                    chk("zero1", int'(zero1), int'(e[8]));
                end
                ack_log.push_back(1);
            end
        end
        prev0 = ack0;
        prev1 = ack1;
    end

    typedef struct {
        logic       who;
        logic [7:0] a, b;
        logic [3:0] op;
        logic [7:0] res;
        logic       z;
    } vec_t;

    vec_t       tbl[6];
    logic [7:0] last_res[2];

    task automatic do_req(input vec_t v);
        int ack_at = 0;
        int occ    = 0;
        @(posedge clk); #1;
        if (v.who) begin
            a1 = v.a; b1 = v.b; op1 = v.op; req1 = 1'b1;
            q1.push_back({v.z, v.res});
        end else begin
            a0 = v.a; b0 = v.b; op0 = v.op; req0 = 1'b1;
            q0.push_back({v.z, v.res});
        end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (ocupado) occ++;
            if ((v.who ? ack1 : ack0) && ack_at == 0) begin
                ack_at = i;
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        chk("ack_latency", ack_at, 3);
        chk("ocupado_cycles", occ, 2);
        chk("other_res_untouched", int'(v.who ? res0 : res1), int'(last_res[~v.who]));
        last_res[v.who] = v.res;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b0, 8'h0A, 8'h02, 4'd0, 8'h0C, 1'b0};
        tbl[1] = '{1'b1, 8'h0A, 8'h0A, 4'd1, 8'h00, 1'b1};
        tbl[2] = '{1'b0, 8'hFF, 8'h01, 4'd0, 8'h00, 1'b1};
        tbl[3] = '{1'b1, 8'h05, 8'h07, 4'd1, 8'hFE, 1'b0};
        tbl[4] = '{1'b0, 8'h80, 8'h80, 4'd1, 8'h00, 1'b1};
        tbl[5] = '{1'b1, 8'h7F, 8'h01, 4'd0, 8'h80, 1'b0};
        last_res[0] = 8'h00;
        last_res[1] = 8'h00;

        req0 = 0; req1 = 0; a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack", int'({ack0, ack1}), 0);
        chk("rst_res", int'({res0, res1}), 0);
        chk("rst_zero", int'({zero0, zero1}), 0);
        chk("rst_alu", int'({alu_a, alu_b, alu_op}), 0);
        chk("rst_ocupado", int'(ocupado), 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) do_req(tbl[i]);

        // Operands change and req drops right after the grant edge.
        @(posedge clk); #1;
        req0 = 1'b1; a0 = 8'h03; b0 = 8'h04; op0 = 4'd0;
        q0.push_back({1'b0, 8'h07});
        @(posedge clk); #1;
        a0 = 8'hFF; req0 = 1'b0;
        @(negedge clk);
        chk("grant_alu_a", int'(alu_a), 8'h03);
        chk("grant_ocupado", int'(ocupado), 1);
        @(negedge clk);
        chk("late_change_ack0", int'(ack0), 1);
        @(negedge clk);
        chk("ack0_cleared", int'(ack0), 0);
        chk("alu_held_idle", int'({alu_a, alu_b, alu_op}), int'({8'h03, 8'h04, 4'd0}));

        // Tie after reset: strict alternation starting with requester 0.
        pulse_reset();
        ack_log.delete();
        @(posedge clk); #1;
        a0 = 8'h01; b0 = 8'h01; op0 = 4'd0;
        a1 = 8'hF6; b1 = 8'h0A; op1 = 4'd0;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 3; i++) q0.push_back({1'b0, 8'h02});
        for (int i = 0; i < 2; i++) q1.push_back({1'b1, 8'h00});
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ack_log.size() >= 5) begin
                req0 = 1'b0; req1 = 1'b0;
                break;
            end
        end
        chk("tie_ack_count", ack_log.size(), 5);
        for (int i = 0; i < 5 && i < ack_log.size(); i++)
            chk("tie_order", ack_log[i], i % 2);
        repeat (3) @(negedge clk);

        // Reset asserted during EXEC aborts the transaction.
        @(posedge clk); #1;
        req0 = 1'b1; a0 = 8'h0A; b0 = 8'h02; op0 = 4'd0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", int'({ack0, ack1}), 0);
        chk("midrst_res", int'({res0, res1, zero0, zero1}), 0);
        chk("midrst_alu", int'({alu_a, alu_b, alu_op}), 0);
        chk("midrst_ocupado", int'(ocupado), 0);
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ack_log.delete();
        @(posedge clk); #1;
        a0 = 8'h10; b0 = 8'h01; op0 = 4'd1;
        a1 = 8'h20; b1 = 8'h01; op1 = 4'd0;
        req0 = 1'b1; req1 = 1'b1;
        q0.push_back({1'b0, 8'h0F});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_log.size() >= 1) begin
                req0 = 1'b0; req1 = 1'b0;
                break;
            end
        end
        chk("post_rst_first_ack_count", ack_log.size(), 1);
        if (ack_log.size() > 0) chk("post_rst_winner", ack_log[0], 0);
        repeat (4) @(negedge clk);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbitro.md
Name: alu_arbitro

Overview:
- Round-robin arbiter and sequencer that shares one combinational 8-bit ALU (operands a/b, 4-bit opcode, result plus zero flag) between two requesters.
- Each requester presents operands and an opcode under a req/ack handshake.
- The block latches the winning request, drives the ALU, registers the result and zero flag, and returns them with a one-cycle ack.
- Sits between the two datapath clients and the single ALU instance.

Parameters:
- WIDTH, 8, operand/result width
- OPW, 4, opcode width

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0  input  1  requester 0 request; held high until ack0
- a0  input  WIDTH  requester 0 operand A
- b0  input  WIDTH  requester 0 operand B
- op0  input  OPW  requester 0 opcode
- ack0  output  1  one-cycle pulse: res0/zero0 valid
- res0  output  WIDTH  result for requester 0
- zero0  output  1  zero flag for requester 0
- req1, a1, b1, op1, ack1, res1, zero1: same as requester 0, for requester 1
- alu_a  output  WIDTH  registered operand A to ALU
- alu_b  output  WIDTH  registered operand B to ALU
- alu_op  output  OPW  registered opcode to ALU
- alu_res  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_zero  input  1  ALU zero flag
- ocupado  output  1  high while state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - alu_a, alu_b, alu_op = 0.
  - ack0, ack1 = 0; res0, res1 = 0; zero0, zero1 = 0.
  - Last-served pointer ult=1, so requester 0 wins the first tie.
- All outputs are registered.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
  - IDLE:
    - No req: stay.
    - Exactly one req: grant it.
    - Both reqs: grant the requester != ult.
    - On grant: load alu_a/alu_b/alu_op from the winner, record gnt, go EXEC.
  - EXEC: unconditional, one cycle for ALU settling.
    - At the edge: capture alu_res/alu_zero into res<gnt>/zero<gnt>, set ack<gnt>=1, ult=gnt, go RESP.
  - RESP: ack<gnt> high for exactly this cycle. At the edge: ack cleared, go IDLE.
- Latency: a req sampled at edge k gives ack high from edge k+1 to edge k+2. Throughput is one operation per 3 cycles.
- res<n>/zero<n> hold their last value until the next completion for the same requester; the other requester's outputs are never touched.
- Requester contract:
  - Operands are sampled only at the grant edge. Later changes on a/b/op have no effect on that transaction.
  - A req that drops after grant does not abort; ack still pulses.
  - A req still high in the cycle after ack is treated as a new request.
- Simultaneous requests alternate strictly (0,1,0,1...) while both are held.
- alu_a/alu_b/alu_op keep the last granted values in IDLE; they are not cleared.
- ack0 and ack1 are never high together.
- Reset mid-transaction aborts with no ack; the result is not delivered.
- Width rule: results pass through unmodified. The zero flag comes from the ALU, not recomputed.

Test Plan:
- Bench fixture: behavioural ALU, op 0=add, op 1=sub, zero=(res==0).
- Single request: req0, a0=8'h0A, b0=8'h02, op0=0 at edge k -> ack0 high from edge k+1 to k+2, res0=8'h0C, zero0=0, ack1 never high, ocupado high 2 cycles.
- Zero flag: req1, a1=8'h0A, b1=8'h0A, op1=1 -> ack1 pulse, res1=8'h00, zero1=1; res0 unchanged at 8'h0C.
- Tie after reset: req0 and req1 rise together (a0=1,b0=1,op0=0; a1=8'hF6,b1=8'h0A,op1=0), both held -> ack0 first (res0=8'h02), ack1 3 cycles later (res1=8'h00, zero1=1); continued holding alternates 0,1,0.
- Operand change after grant: change a0 to 8'hFF one cycle after grant -> res0 still reflects the sampled value.
- Reset mid-op: assert rst_n low during EXEC -> no ack, all outputs 0 immediately (async); after release, a tie grants requester 0.
